// File: rtl/speed_arbiter_if.sv
// speed_arbiter_if: frame tick, game inputs and speed/state outputs of the speed arbiter.
interface speed_arbiter_if;
    logic       startOfFrame;
    logic       game_active;
    logic       faster_key;
    logic       slower_key;
    logic       crash;
    logic       finish;
    logic       fuel_empty;
    logic [4:0] speed;
    logic [2:0] state;
    logic       speed_change;
    logic       crash_active;
    modport master (
        output startOfFrame, game_active, faster_key, slower_key, crash, finish, fuel_empty,
        input  speed, state, speed_change, crash_active
    );
    modport slave (
        input  startOfFrame, game_active, faster_key, slower_key, crash, finish, fuel_empty,
        output speed, state, speed_change, crash_active
    );
endinterface

// File: rtl/speed_arbiter.sv
// speed_arbiter: frame-paced speed FSM (launch, run, crash, coast, stop) with latched crash/finish events.
module speed_arbiter #(
    parameter int MAX_SPEED    = 27,
    parameter int CRUISE_MIN   = 12,
    parameter int STEP_FRAMES  = 10,
    parameter int CRASH_FRAMES = 45
) (
    input logic           clk,
    input logic           resetN,
    speed_arbiter_if.slave bus
);
    localparam int SW = $clog2(STEP_FRAMES + 1);
    localparam int CW = $clog2(CRASH_FRAMES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        CRASH  = 3'd3,
        COAST  = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t        state;
    logic [4:0]    speed;
    logic [4:0]    speed_d;
    logic [SW-1:0] step;
    logic [CW-1:0] ccnt;
    logic [1:0]    last_dir;
    logic          crash_pend;
    logic          finish_pend;

    logic          crash_eff;
    logic          finish_eff;
    logic [1:0]    dir;
    logic [SW-1:0] step_inc;
    logic          step_hit;
    logic          dir_flip;
    logic          moving;

    // A pulse landing on the tick cycle itself is consumed by that tick.
    always_comb begin
        crash_eff  = crash_pend | bus.crash;
        finish_eff = finish_pend | bus.finish;
        dir        = bus.faster_key ? 2'd1 : bus.slower_key ? 2'd2 : 2'd0;
        step_inc   = step + 1'b1;
        step_hit   = step_inc == SW'(STEP_FRAMES);
        dir_flip   = dir != 2'd0 && last_dir != 2'd0 && dir != last_dir;
        moving     = state == LAUNCH || state == RUN || state == COAST;
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state       <= IDLE;
            speed       <= '0;
            speed_d     <= '0;
            step        <= '0;
            ccnt        <= '0;
            last_dir    <= '0;
            crash_pend  <= 1'b0;
            finish_pend <= 1'b0;
        end else begin
            speed_d <= speed;
            if (!bus.startOfFrame) begin
                crash_pend  <= crash_eff;
                finish_pend <= finish_eff;
            end else if (!bus.game_active) begin
                state       <= IDLE;
                speed       <= '0;
                step        <= '0;
                ccnt        <= '0;
                last_dir    <= '0;
                crash_pend  <= 1'b0;
                finish_pend <= 1'b0;
            end else begin
                crash_pend  <= 1'b0;
                finish_pend <= finish_eff;
                last_dir    <= 2'd0;
                if (moving && crash_eff) begin
                    state <= CRASH;
                    speed <= '0;
                    step  <= '0;
                    ccnt  <= CW'(CRASH_FRAMES);
                end else if (moving && finish_eff) begin
                    state       <= STOP;
                    step        <= '0;
                    finish_pend <= 1'b0;
                end else if ((state == LAUNCH || state == RUN) && bus.fuel_empty) begin
                    state <= COAST;
                    step  <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            state       <= LAUNCH;
                            step        <= '0;
                            finish_pend <= 1'b0;
                        end
                        LAUNCH: begin
                            step <= step_hit ? '0 : step_inc;
                            if (step_hit) begin
                                speed <= speed < 5'(MAX_SPEED) ? speed + 5'd1 : speed;
                                if (speed + 5'd1 == 5'(CRUISE_MIN))
                                    state <= RUN;
                            end
                        end
                        RUN: begin
                            last_dir <= dir;
                            if (dir == 2'd0 || dir_flip)
                                step <= '0;
                            else begin
                                step <= step_hit ? '0 : step_inc;
                                if (step_hit)
                                    speed <= dir == 2'd1 ? (speed < 5'(MAX_SPEED) ? speed + 5'd1 : speed)
                                                         : (speed > 5'(CRUISE_MIN) ? speed - 5'd1 : speed);
                            end
                        end
                        COAST: begin
                            if (speed == 5'd0)
                                state <= STOP;
                            else begin
                                step <= step_hit ? '0 : step_inc;
                                if (step_hit) begin
                                    speed <= speed - 5'd1;
                                    if (speed == 5'd1)
                                        state <= STOP;
                                end
                            end
                        end
                        // A finish seen during the crash waits here and decides the exit.
                        CRASH: begin
                            if (crash_eff)
                                ccnt <= CW'(CRASH_FRAMES);
                            else if (ccnt <= CW'(1)) begin
                                ccnt        <= '0;
                                step        <= '0;
                                finish_pend <= 1'b0;
                                state       <= finish_eff ? STOP : bus.fuel_empty ? COAST : LAUNCH;
                            end else
                                ccnt <= ccnt - 1'b1;
                        end
                        STOP: begin
                            speed       <= speed == 5'd0 ? 5'd0 : speed - 5'd1;
                            finish_pend <= 1'b0;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.speed        = speed;
    assign bus.state        = state;
    assign bus.speed_change = speed != speed_d;
    assign bus.crash_active = state == CRASH;
endmodule

// File: tb/tb_speed_arbiter.sv
// tb_speed_arbiter: directed frame-tick scenarios with hand-computed expectations.
module tb_speed_arbiter;
    logic clk = 1'b0;
    logic resetN = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   pulses = 0;

    speed_arbiter_if bus();
    speed_arbiter dut (.clk(clk), .resetN(resetN), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) bus.startOfFrame = 1'b1;
        @(negedge clk) bus.startOfFrame = 1'b0;
        if (bus.speed_change) pulses++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_crash();
        @(negedge clk) bus.crash = 1'b1;
        @(negedge clk) bus.crash = 1'b0;
    endtask

    task automatic pulse_finish();
        @(negedge clk) bus.finish = 1'b1;
        @(negedge clk) bus.finish = 1'b0;
    endtask

    task automatic launch_to_run(input string tag);
        pulses = 0;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (i == 10) check({tag, "_spd_t10"}, bus.speed, 1);
            if (i == 119) check({tag, "_state_t119"}, bus.state, 1);
        end
        check({tag, "_state_t120"}, bus.state, 2);
        check({tag, "_spd_t120"}, bus.speed, 12);
        check({tag, "_pulses"}, pulses, 12);
    endtask

    initial begin
        bus.startOfFrame = 0; bus.game_active = 0; bus.faster_key = 0; bus.slower_key = 0;
        bus.crash = 0; bus.finish = 0; bus.fuel_empty = 0;
        repeat (2) @(negedge clk);
        check("rst_state", bus.state, 0);
        check("rst_speed", bus.speed, 0);
        check("rst_sc", bus.speed_change, 0);
        check("rst_ca", bus.crash_active, 0);
        resetN = 1'b0;

        bus.game_active = 1;
        tick();
        check("launch_state", bus.state, 1);
        check("launch_speed", bus.speed, 0);
        launch_to_run("l1");

        bus.faster_key = 1;
        ticks(140);
        check("run_up_26", bus.speed, 26);
        bus.faster_key = 0;
        tick();
        bus.faster_key = 1;
        pulses = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 9) check("max_t9", bus.speed, 26);
            if (i == 10) check("max_t10", bus.speed, 27);
        end
        check("max_hold", bus.speed, 27);
        check("max_pulses", pulses, 1);
        bus.faster_key = 0;
        tick();

        bus.slower_key = 1;
        ticks(120);
        check("down_15", bus.speed, 15);
        bus.slower_key = 0;
        tick();
        bus.faster_key = 1; bus.slower_key = 1;
        ticks(10);
        check("both_16", bus.speed, 16);
        bus.faster_key = 0; bus.slower_key = 0;
        tick();
        bus.slower_key = 1;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (i == 39) check("floor_t39", bus.speed, 13);
        end
        check("floor_hold", bus.speed, 12);
        check("floor_state", bus.state, 2);
        bus.slower_key = 0;
        tick();

        bus.faster_key = 1;
        ticks(80);
        check("run_20", bus.speed, 20);
        bus.faster_key = 0;
        tick();
        pulse_crash();
        check("crash_offtick_state", bus.state, 2);
        check("crash_offtick_spd", bus.speed, 20);
        tick();
        check("crash_state", bus.state, 3);
        check("crash_speed", bus.speed, 0);
        check("crash_active", bus.crash_active, 1);
        ticks(44);
        check("crash_t44", bus.state, 3);
        tick();
        check("crash_exit_state", bus.state, 1);
        check("crash_exit_ca", bus.crash_active, 0);

        pulse_crash();
        tick();
        check("crash2_state", bus.state, 3);
        ticks(30);
        pulse_crash();
        tick();
        pulse_finish();
        ticks(44);
        check("reload_t44", bus.state, 3);
        tick();
        check("finish_exit_state", bus.state, 5);
        check("finish_exit_spd", bus.speed, 0);
        ticks(3);
        check("stop_hold_state", bus.state, 5);

        bus.game_active = 0;
        tick();
        check("idle_state", bus.state, 0);
        bus.game_active = 1;
        tick();
        launch_to_run("l2");
        bus.faster_key = 1;
        ticks(20);
        check("run_14", bus.speed, 14);
        bus.faster_key = 0;
        bus.fuel_empty = 1;
        tick();
        check("coast_state", bus.state, 4);
        check("coast_speed", bus.speed, 14);
        pulses = 0;
        for (int i = 1; i <= 140; i++) begin
            tick();
            if (i == 10) check("coast_t10", bus.speed, 13);
            if (i == 139) check("coast_t139_state", bus.state, 4);
        end
        check("coast_end_state", bus.state, 5);
        check("coast_end_speed", bus.speed, 0);
        check("coast_pulses", pulses, 14);
        bus.game_active = 0;
        tick();
        check("drop_idle", bus.state, 0);

        bus.game_active = 1;
        ticks(2);
        check("fuel_coast", bus.state, 4);
        pulse_finish();
        @(negedge clk) resetN = 1'b1;
        @(negedge clk);
        check("midrst_state", bus.state, 0);
        check("midrst_speed", bus.speed, 0);
        check("midrst_ca", bus.crash_active, 0);
        resetN = 1'b0;
        bus.fuel_empty = 0;
        ticks(2);
        check("no_pend_survive", bus.state, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
